// File: rtl/legv8_control_unit.sv
// LEGv8 multicycle control unit: FETCH -> DECODE -> EXECUTE, HALT on unsupported opcodes.
// Latency: 3 cycles per instruction minimum; ControlWord/constant are registered and live only in EXECUTE.
// Backpressure: stays in FETCH with instr_req=1 until instr_valid; HALT drops instr_req until reset.
module legv8_control_unit (
    input  logic        clock,
    input  logic        reset,
    output logic        instr_req,
    output logic [63:0] instr_addr,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    input  logic [3:0]  status,
    output logic [24:0] ControlWord,
    output logic [63:0] constant,
    output logic [63:0] pc,
    output logic        halted
);

    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_EOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [63:0] pc_q, pc_d;
    logic [24:0] cw_q, cw_d;
    logic [63:0] const_q, const_d;
    logic        halted_q, halted_d;
    // Held low through reset so instr_req only rises on the first edge after release.
    logic        req_en_q;

    logic [24:0] dec_cw;
    logic [63:0] dec_const;
    logic        dec_ok;
    logic [4:0]  rn, rm, rd;
    logic        is_b, is_cbz;
    logic [63:0] b_off, cbz_off;
    logic        unused_status;

    assign unused_status = ^status[3:1];

    function automatic logic [24:0] pack_cw(
        input logic [4:0] sa,
        input logic [4:0] sb,
        input logic [4:0] da,
        input logic       reg_write,
        input logic       mem_write,
        input logic [4:0] fs,
        input logic       bsel,
        input logic       en_mem,
        input logic       en_alu
    );
        return {sa, sb, da, reg_write, mem_write, fs, bsel, en_mem, en_alu};
    endfunction

    assign rn = ir_q[9:5];
    assign rm = ir_q[20:16];
    assign rd = ir_q[4:0];

    // Instruction decode from the held IR; dec_ok=0 marks an unsupported opcode.
    always_comb begin
        dec_cw    = '0;
        dec_const = '0;
        dec_ok    = 1'b1;
        casez (ir_q[31:21])
            11'b10001011000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b1);
            11'b11001011000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_SUB, 1'b0, 1'b0, 1'b1);
            11'b10001010000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_AND, 1'b0, 1'b0, 1'b1);
            11'b10101010000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_ORR, 1'b0, 1'b0, 1'b1);
            11'b11001010000: dec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, FS_EOR, 1'b0, 1'b0, 1'b1);
            11'b1001000100?: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b1);
                dec_const = {52'd0, ir_q[21:10]};
            end
            11'b1101000100?: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_SUB, 1'b1, 1'b0, 1'b1);
                dec_const = {52'd0, ir_q[21:10]};
            end
            11'b1001001000?: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_AND, 1'b1, 1'b0, 1'b1);
                dec_const = {52'd0, ir_q[21:10]};
            end
            11'b1011001000?: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_ORR, 1'b1, 1'b0, 1'b1);
                dec_const = {52'd0, ir_q[21:10]};
            end
            11'b1101001000?: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_EOR, 1'b1, 1'b0, 1'b1);
                dec_const = {52'd0, ir_q[21:10]};
            end
            11'b11010011011: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_LSL, 1'b1, 1'b0, 1'b1);
                dec_const = {58'd0, ir_q[15:10]};
            end
            11'b11010011010: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_LSR, 1'b1, 1'b0, 1'b1);
                dec_const = {58'd0, ir_q[15:10]};
            end
            11'b11111000010: begin
                dec_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_ADD, 1'b1, 1'b1, 1'b0);
                dec_const = {{55{ir_q[20]}}, ir_q[20:12]};
            end
            11'b11111000000: begin
                dec_cw    = pack_cw(rn, rd, 5'd0, 1'b0, 1'b1, FS_ADD, 1'b1, 1'b1, 1'b0);
                dec_const = {{55{ir_q[20]}}, ir_q[20:12]};
            end
            // CBZ passes Rt through the adder against XZR so the datapath raises Z.
            11'b10110100???: dec_cw = pack_cw(5'd31, rd, 5'd0, 1'b0, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b0);
            11'b000101?????: dec_cw = '0;
            default:         dec_ok = 1'b0;
        endcase
    end

    assign is_b    = (ir_q[31:26] == 6'b000101);
    assign is_cbz  = (ir_q[31:24] == 8'b10110100);
    assign b_off   = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
    assign cbz_off = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};

    // Next-state, IR, PC and registered-output computation.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_d     = pc_q;
        cw_d     = '0;
        const_d  = '0;
        halted_d = halted_q;
        case (state_q)
            FETCH: begin
                if (instr_req && instr_valid) begin
                    ir_d    = instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_ok) begin
                    cw_d    = dec_cw;
                    const_d = dec_const;
                    state_d = EXECUTE;
                end else begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end
            end
            EXECUTE: begin
                state_d = FETCH;
                if (is_b)
                    pc_d = pc_q + b_off;
                else if (is_cbz && status[0])
                    pc_d = pc_q + cbz_off;
                else
                    pc_d = pc_q + 64'd4;
            end
            default: state_d = HALT;
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            ir_q     <= '0;
            pc_q     <= '0;
            cw_q     <= '0;
            const_q  <= '0;
            halted_q <= 1'b0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            pc_q     <= pc_d;
            cw_q     <= cw_d;
            const_q  <= const_d;
            halted_q <= halted_d;
            req_en_q <= 1'b1;
        end
    end

    assign instr_req   = req_en_q && (state_q == FETCH);
    assign instr_addr  = pc_q;
    assign pc          = pc_q;
    assign ControlWord = cw_q;
    assign constant    = const_q;
    assign halted      = halted_q;

endmodule

// File: doc/legv8_control_unit.md
LEGV8_CONTROL_UNIT -- requirements
Module: legv8_control_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clock.
REQ-002 Port clock SHALL be an input, 1 bit: system clock.
REQ-003 Port reset SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-004 Port instr_req SHALL be an output, 1 bit: instruction fetch request.
REQ-005 Port instr_addr SHALL be an output, 64 bits: fetch address, equal to pc.
REQ-006 Port instr_valid SHALL be an input, 1 bit: instr is valid this cycle.
REQ-007 Port instr SHALL be an input, 32 bits: LEGv8 instruction word.
REQ-008 Port status SHALL be an input, 4 bits: datapath flags; bit 0 is Z.
REQ-009 Port ControlWord SHALL be an output, 25 bits, packed as {SA[24:20], SB[19:15], DA[14:10], RegWrite[9], MemWrite[8], FS[7:3], Bsel[2], EN_Mem[1], EN_ALU[0]}.
REQ-010 Port constant SHALL be an output, 64 bits: datapath immediate (B operand when Bsel=1).
REQ-011 Port pc SHALL be an output, 64 bits: program counter.
REQ-012 Port halted SHALL be an output, 1 bit: set when an unsupported opcode has been decoded.

Function
REQ-013 The FSM SHALL have four states: FETCH, DECODE, EXECUTE, HALT.
REQ-014 In FETCH, instr_req SHALL be 1; on instr_valid=1, IR SHALL capture instr and the next state SHALL be DECODE; otherwise the FSM SHALL remain in FETCH.
REQ-015 instr_valid SHALL be ignored in every state other than FETCH.
REQ-016 DECODE SHALL last one cycle, registering ControlWord and constant from IR, with next state EXECUTE.
REQ-017 EXECUTE SHALL last one cycle, holding the registered ControlWord; next state SHALL be FETCH.
REQ-018 Outside EXECUTE, ControlWord SHALL be 25'b0 and constant SHALL be 64'd0.
REQ-019 Minimum latency SHALL be 3 cycles per instruction (instr_valid in the first FETCH cycle).
REQ-020 FS encoding: bit0 = Ainvert, bit1 = Binvert, [4:2] = 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR.
REQ-021 R-type decodes (SA=Rn, SB=Rm, DA=Rd, RegWrite=1, Bsel=0, EN_ALU=1): ADD 10001011000 → FS=01000; SUB 11001011000 → 01010; AND 10001010000 → 00000; ORR 10101010000 → 00100; EOR 11001010000 → 01100.
REQ-022 I-type decodes (opcode [31:22]) SHALL use Bsel=1, constant = zero-extended imm12, and R-type FS per operation: ADDI 1001000100, SUBI 1101000100, ANDI 1001001000, ORRI 1011001000, EORI 1101001000.
REQ-023 LSL 11010011011 / LSR 11010011010 SHALL use SA=Rn, DA=Rd, Bsel=1, constant = zero-extended shamt[15:10], FS=10000 / 10100.
REQ-024 LDUR 11111000010 SHALL use SA=Rn, DA=Rt, RegWrite=1, FS=01000, Bsel=1, EN_Mem=1, EN_ALU=0, constant = sign-extended imm9[20:12].
REQ-025 STUR 11111000000 SHALL use SA=Rn, SB=Rt, MemWrite=1, RegWrite=0, FS=01000, Bsel=1, EN_Mem=1, EN_ALU=0, constant = sign-extended imm9.
REQ-026 CBZ 10110100 SHALL use SA=31, SB=Rt, FS=01000, Bsel=0, with no writes; Z is sampled at the end of EXECUTE.
REQ-027 B 000101 SHALL drive ControlWord=0.
REQ-028 PC update SHALL occur at the end of EXECUTE:
- B: pc + (sext(imm26) << 2)
- CBZ with Z=1: pc + (sext(imm19) << 2)
- otherwise: pc + 4
REQ-029 All PC arithmetic SHALL be modulo 2^64; wrap-around is permitted.
REQ-030 An unsupported opcode SHALL, at DECODE, send the FSM to HALT, set halted=1, and leave pc unchanged.
REQ-031 In HALT, instr_req SHALL be 0 and ControlWord SHALL be 0 until reset.

Reset
REQ-032 On reset=0, the following SHALL apply immediately, independent of clock:
- state = FETCH, pc = 0, IR = 0
- ControlWord = 0, constant = 0, halted = 0
- instr_req = 0 while reset is asserted
REQ-033 Reset asserted in any state, including mid-EXECUTE, SHALL abort the instruction with no further RegWrite or MemWrite.
REQ-034 After reset deasserts, instr_req SHALL assert from the next rising edge.

Verification
REQ-035 ADDI X5, XZR, #4 (0x910013E5) with instr_valid immediate: EXECUTE drives ControlWord = 25'b1111100000001011001000101, constant = 4, and pc becomes 4.
REQ-036 SUB X30, X15, X12 (0xCB0C01FE): ControlWord = 25'b0111101100111101001010001.
REQ-037 CBZ X1, #+8 (imm19=2): with status[0]=1, pc goes 0 → 8; with status[0]=0, pc goes 0 → 4.
REQ-038 B #-1 at pc=0: pc becomes 64'hFFFFFFFFFFFFFFFC (wrap-around).
REQ-039 instr_valid held low for 5 cycles: FSM remains in FETCH, ControlWord stays 0, and instr_req stays 1.
REQ-040 Opcode 0x00000000: halted=1 and instr_req=0; reset pulsed low mid-EXECUTE of STUR: MemWrite drops to 0 immediately and pc = 0.
